i2s_rx: RTL and testbench

// - Slave-mode I2S receiver: takes the SGTL5000 ADC stream (I2S_DOUT) with the codec-driven SCLK/LRCLK.
// - Delivers stereo PCM frames to the FPGA fabric on a valid/ready interface.
// - Complements the I2S transmit path that drives I2S_DIN. Port names match the top-level nets so `.*` hookup works.
// - Runs entirely in the 50 MHz system domain and oversamples the codec clocks; no second clock.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_pin_sync.sv | 32 +++
 rtl/i2s_rx.sv | 182 ++++++++++++++++++
 tb/tb_i2s_rx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receive FSM states, channel encoding and default
// sample width used by both the receive and transmit paths.
package i2s_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } i2s_rx_state_t;

  localparam logic I2S_LEFT        = 1'b0;
  localparam int   I2S_WIDTH       = 16;
  localparam int   I2S_SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_pin_sync.sv
// Multi-flop synchronizer for asynchronous codec pins; one pin additionally
// gets a rising-edge detector driven from a history flop.
module i2s_pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int PINS        = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            edge_pin,
  input  logic [PINS-1:0] level_pins,
  output logic [PINS-1:0] level_sync,
  output logic            edge_rise
);

  logic [SYNC_STAGES-1:0][PINS:0] stage_r;
  logic                           edge_hist_r;

  // Shift every pin through the synchronizer; remember the last synchronized edge-pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r     <= '0;
      edge_hist_r <= 1'b0;
    end else begin
      stage_r     <= {stage_r[SYNC_STAGES-2:0], {level_pins, edge_pin}};
      edge_hist_r <= stage_r[SYNC_STAGES-1][0];
    end
  end

  assign level_sync = stage_r[SYNC_STAGES-1][PINS:1];
  assign edge_rise  = stage_r[SYNC_STAGES-1][0] & ~edge_hist_r;

endmodule

// File: rtl/i2s_rx.sv
// Slave-mode I2S receiver: oversamples codec SCLK/LRCLK/DOUT in the 50 MHz
// domain and presents stereo frames on a valid/ready interface.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int WIDTH       = I2S_WIDTH,
  parameter int SYNC_STAGES = I2S_SYNC_STAGES
) (
  input  logic             MAX10_CLK1_50,
  input  logic             reset_n,
  input  logic             I2S_SCLK,
  input  logic             I2S_LRCLK,
  input  logic             I2S_DOUT,
  output logic [WIDTH-1:0] left_sample,
  output logic [WIDTH-1:0] right_sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  output logic             frame_err,
  output logic             locked
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       pins_sync_s;
  logic             rise_evt_s;
  logic             lr_s;
  logic             dout_s;

  i2s_rx_state_t    state_r;
  i2s_rx_state_t    state_nxt_s;
  logic             lr_prev_r;
  logic [CW-1:0]    bitcnt_r;
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] sh_nxt_s;
  logic [WIDTH-1:0] left_hold_r;
  logic             left_ok_r;
  logic             commit_pend_r;

  logic             boundary_s;
  logic             capture_s;
  logic             word_done_s;
  logic             lock_set_s;
  logic             err_s;
  logic             left_load_s;
  logic             frame_done_s;

  logic [WIDTH-1:0] left_sample_r;
  logic [WIDTH-1:0] right_sample_r;
  logic             valid_r;
  logic             overrun_r;
  logic             frame_err_r;
  logic             locked_r;

  i2s_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .PINS        (2)
  ) u_pin_sync (
    .clk        (MAX10_CLK1_50),
    .rst_n      (reset_n),
    .edge_pin   (I2S_SCLK),
    .level_pins ({I2S_DOUT, I2S_LRCLK}),
    .level_sync (pins_sync_s),
    .edge_rise  (rise_evt_s)
  );

  assign lr_s   = pins_sync_s[0];
  assign dout_s = pins_sync_s[1];

  // Decode the per-SCLK events: slot boundary, bit capture and word completion
  always_comb begin
    boundary_s  = rise_evt_s && (lr_s != lr_prev_r);
    capture_s   = rise_evt_s && !boundary_s && (bitcnt_r < CNT_FULL);
    word_done_s = capture_s && (bitcnt_r == CNT_LAST);
    sh_nxt_s    = {sh_r[WIDTH-2:0], dout_s};
  end

  // Next-state logic; transitions only ever happen on a boundary
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_SYNC: begin
        if (boundary_s && (lr_s == I2S_LEFT)) state_nxt_s = LEFT;
        else                                  state_nxt_s = WAIT_SYNC;
      end
      LEFT, RIGHT: begin
        if (boundary_s) state_nxt_s = (lr_s == I2S_LEFT) ? LEFT : RIGHT;
        else            state_nxt_s = state_r;
      end
      default: state_nxt_s = WAIT_SYNC;
    endcase
  end

  // FSM action decode; a boundary in the wrong direction is flagged like a short slot
  always_comb begin
    lock_set_s   = 1'b0;
    err_s        = 1'b0;
    left_load_s  = 1'b0;
    frame_done_s = 1'b0;
    case (state_r)
      WAIT_SYNC: lock_set_s = boundary_s && (lr_s == I2S_LEFT);
      LEFT: begin
        err_s       = boundary_s && ((bitcnt_r < CNT_FULL) || (lr_s == I2S_LEFT));
        left_load_s = word_done_s;
      end
      RIGHT: begin
        err_s        = boundary_s && ((bitcnt_r < CNT_FULL) || (lr_s != I2S_LEFT));
        frame_done_s = word_done_s && left_ok_r;
      end
      default: lock_set_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) state_r <= WAIT_SYNC;
    else          state_r <= state_nxt_s;
  end

  // Bit counter, shift register and the left word held until its right partner arrives
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      lr_prev_r     <= I2S_LEFT;
      bitcnt_r      <= '0;
      sh_r          <= '0;
      left_hold_r   <= '0;
      left_ok_r     <= 1'b0;
      commit_pend_r <= 1'b0;
    end else begin
      commit_pend_r <= frame_done_s;
      if (rise_evt_s) begin
        lr_prev_r <= lr_s;
        if (boundary_s) begin
          bitcnt_r <= '0;
        end else if (capture_s) begin
          sh_r     <= sh_nxt_s;
          bitcnt_r <= bitcnt_r + CW'(1);
        end
      end
      if (left_load_s) left_hold_r <= sh_nxt_s;
      if (left_load_s)                                   left_ok_r <= 1'b1;
      else if (err_s || frame_done_s || lock_set_s)      left_ok_r <= 1'b0;
    end
  end

  // Output handshake: sh_r still holds the right word in the cycle after completion
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      left_sample_r  <= '0;
      right_sample_r <= '0;
      valid_r        <= 1'b0;
      overrun_r      <= 1'b0;
      frame_err_r    <= 1'b0;
      locked_r       <= 1'b0;
    end else begin
      overrun_r   <= 1'b0;
      frame_err_r <= err_s;
      if (lock_set_s) locked_r <= 1'b1;
      if (commit_pend_r) begin
        if (!valid_r || sample_ready) begin
          left_sample_r  <= left_hold_r;
          right_sample_r <= sh_r;
          valid_r        <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (valid_r && sample_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign left_sample  = left_sample_r;
  assign right_sample = right_sample_r;
  assign sample_valid = valid_r;
  assign overrun      = overrun_r;
  assign frame_err    = frame_err_r;
  assign locked       = locked_r;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: a clocked codec model drives 32-bit I2S slots and a
// frame-level reference predicts lock, errors, commits and the handshake.
module tb_i2s_rx;

  localparam int W          = 16;
  localparam int SYNC       = 2;
  localparam int HALF       = 8;
  localparam int EVT_LAT    = SYNC + 1;
  localparam int COMMIT_LAT = SYNC + 2;

  logic         MAX10_CLK1_50 = 1'b0;
  logic         reset_n       = 1'b0;
  logic         I2S_SCLK      = 1'b0;
  logic         I2S_LRCLK     = 1'b1;
  logic         I2S_DOUT      = 1'b0;
  logic         sample_ready  = 1'b0;
  logic [W-1:0] left_sample;
  logic [W-1:0] right_sample;
  logic         sample_valid;
  logic         overrun;
  logic         frame_err;
  logic         locked;

  always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  i2s_rx #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .MAX10_CLK1_50 (MAX10_CLK1_50),
    .reset_n       (reset_n),
    .I2S_SCLK      (I2S_SCLK),
    .I2S_LRCLK     (I2S_LRCLK),
    .I2S_DOUT      (I2S_DOUT),
    .left_sample   (left_sample),
    .right_sample  (right_sample),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun),
    .frame_err     (frame_err),
    .locked        (locked)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int           at;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } commit_t;

  int      cyc = 0;
  int      q_lock[$];
  int      q_err[$];
  commit_t q_commit[$];

  logic         m_valid = 1'b0, m_locked = 1'b0, m_ovr = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_l = '0, m_r = '0;

  logic         b_prev_lr = 1'b0;
  bit           b_synced = 1'b0;
  int           b_cnt = W;
  bit           b_left_ok = 1'b0;
  logic [W-1:0] b_left = '0;

  bit rand_ready = 1'b0;
  bit arm_coincide = 1'b0;
  int ready_arm = -1;

  int           n_acc = 0, n_ovr_seen = 0, n_err_seen = 0;
  logic [W-1:0] acc_l = '0, acc_r = '0;
  logic         prev_valid = 1'b0;
  logic [W-1:0] prev_l = '0, prev_r = '0;

  // Reference handshake: applies scheduled lock/error/commit events each clock
  initial forever begin
    commit_t c;
    @(posedge MAX10_CLK1_50);
    cyc++;
    m_ovr = 1'b0;
    m_err = 1'b0;
    if (reset_n) begin
      while (q_lock.size() > 0 && q_lock[0] <= cyc) begin
        void'(q_lock.pop_front());
        m_locked = 1'b1;
      end
      while (q_err.size() > 0 && q_err[0] <= cyc) begin
        void'(q_err.pop_front());
        m_err = 1'b1;
      end
      if (q_commit.size() > 0 && q_commit[0].at == cyc) begin
        c = q_commit.pop_front();
        if (!m_valid || sample_ready) begin
          m_valid = 1'b1;
          m_l     = c.l;
          m_r     = c.r;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && sample_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the reference, plus accept/pulse bookkeeping
  initial forever begin
    @(negedge MAX10_CLK1_50);
    if (reset_n) begin
      check_eq("valid", sample_valid, m_valid);
      if (m_valid) begin
        check_eq("left", left_sample, m_l);
        check_eq("right", right_sample, m_r);
      end
      check_eq("overrun", overrun, m_ovr);
      check_eq("frame_err", frame_err, m_err);
      check_eq("locked", locked, m_locked);
      if (prev_valid && sample_ready) begin
        n_acc++;
        acc_l = prev_l;
        acc_r = prev_r;
      end
      n_ovr_seen += int'(overrun);
      n_err_seen += int'(frame_err);
      prev_valid = sample_valid;
      prev_l     = left_sample;
      prev_r     = right_sample;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(negedge MAX10_CLK1_50);
    #1;
    if (rand_ready) sample_ready = 1'($urandom_range(0, 1));
    if (ready_arm >= 0 && cyc == ready_arm) begin
      sample_ready = 1'b1;
      ready_arm    = -1;
    end
  endtask

  // Frame-level codec view of one SCLK rising edge
  task automatic model_rise(input logic lr, input logic [W-1:0] word);
    if (lr != b_prev_lr) begin
      if (!b_synced) begin
        if (lr == 1'b0) begin
          b_synced = 1'b1;
          q_lock.push_back(cyc + EVT_LAT);
        end
      end else if (b_cnt < W) begin
        q_err.push_back(cyc + EVT_LAT);
        b_left_ok = 1'b0;
      end
      b_cnt     = 0;
      b_prev_lr = lr;
    end else if (b_cnt < W) begin
      b_cnt++;
      if (b_cnt == W && b_synced) begin
        if (lr == 1'b0) begin
          b_left_ok = 1'b1;
          b_left    = word;
        end else if (b_left_ok) begin
          q_commit.push_back('{at: cyc + COMMIT_LAT, l: b_left, r: word});
          b_left_ok = 1'b0;
          if (arm_coincide) begin
            ready_arm    = cyc + COMMIT_LAT - 1;
            arm_coincide = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic sclk_bit(input logic lr, input logic d, input logic [W-1:0] word);
    tick();
    I2S_SCLK  = 1'b0;
    I2S_LRCLK = lr;
    I2S_DOUT  = d;
    repeat (HALF - 1) tick();
    tick();
    I2S_SCLK = 1'b1;
    model_rise(lr, word);
    repeat (HALF - 1) tick();
  endtask

  task automatic send_slot(input logic lr, input logic [W-1:0] word, input int nbits);
    logic d;
    for (int i = 0; i < nbits; i++) begin
      if (i >= 1 && i <= W) d = word[W-i];
      else                  d = 1'($urandom_range(0, 1));
      sclk_bit(lr, d, word);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  task automatic do_reset();
    @(negedge MAX10_CLK1_50);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("rst_valid", sample_valid, 1'b0);
    check_eq("rst_left", left_sample, 16'h0000);
    check_eq("rst_right", right_sample, 16'h0000);
    check_eq("rst_overrun", overrun, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    check_eq("rst_locked", locked, 1'b0);
    q_lock.delete();
    q_err.delete();
    q_commit.delete();
    m_valid = 1'b0; m_locked = 1'b0; m_ovr = 1'b0; m_err = 1'b0;
    b_prev_lr = 1'b0; b_synced = 1'b0; b_cnt = W; b_left_ok = 1'b0;
    ready_arm = -1; arm_coincide = 1'b0;
    I2S_SCLK = 1'b0;
    repeat (4) @(negedge MAX10_CLK1_50);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] fl[4];
    logic [W-1:0] fr[4];
    int base_acc, base_ovr, base_err;

    // Reset released in the middle of a right slot
    do_reset();
    sample_ready = 1'b1;
    send_slot(1'b1, 16'(($urandom)), 20);
    check_eq("lock_early", locked, 1'b0);
    check_eq("valid_early", sample_valid, 1'b0);
    send_frame(16'h8001, 16'h7FFE);
    check_eq("first_cnt", n_acc, 1);
    check_eq("first_left", acc_l, 16'h8001);
    check_eq("first_right", acc_r, 16'h7FFE);
    check_eq("lock_on", locked, 1'b1);

    for (int k = 0; k < 3; k++) begin
      fl[0] = 16'($urandom);
      fr[0] = 16'($urandom);
      send_frame(fl[0], fr[0]);
      check_eq("rnd_left", acc_l, fl[0]);
      check_eq("rnd_right", acc_r, fr[0]);
    end

    // Consumer stalls for three frames
    sample_ready = 1'b0;
    base_acc = n_acc;
    base_ovr = n_ovr_seen;
    for (int k = 0; k < 4; k++) begin
      fl[k] = 16'($urandom);
      fr[k] = 16'($urandom);
    end
    for (int k = 0; k < 3; k++) send_frame(fl[k], fr[k]);
    check_eq("stall_valid", sample_valid, 1'b1);
    check_eq("stall_left", left_sample, fl[0]);
    check_eq("stall_right", right_sample, fr[0]);
    check_eq("stall_ovr_cnt", n_ovr_seen - base_ovr, 2);
    sample_ready = 1'b1;
    send_frame(fl[3], fr[3]);
    check_eq("stall_acc_cnt", n_acc - base_acc, 2);
    check_eq("after_left", acc_l, fl[3]);
    check_eq("after_right", acc_r, fr[3]);

    // Accept lands in the same cycle as the next commit
    sample_ready = 1'b0;
    base_acc = n_acc;
    base_ovr = n_ovr_seen;
    fl[0] = 16'($urandom); fr[0] = 16'($urandom);
    fl[1] = 16'($urandom); fr[1] = 16'($urandom);
    send_frame(fl[0], fr[0]);
    arm_coincide = 1'b1;
    send_frame(fl[1], fr[1]);
    check_eq("coin_ovr_cnt", n_ovr_seen - base_ovr, 0);
    check_eq("coin_acc_cnt", n_acc - base_acc, 2);
    check_eq("coin_left", acc_l, fl[1]);
    check_eq("coin_right", acc_r, fr[1]);

    // Left slot cut short after 10 SCLKs
    base_acc = n_acc;
    base_err = n_err_seen;
    send_slot(1'b0, 16'($urandom), 10);
    send_slot(1'b1, 16'($urandom), 32);
    fl[0] = 16'($urandom); fr[0] = 16'($urandom);
    send_frame(fl[0], fr[0]);
    check_eq("short_err_cnt", n_err_seen - base_err, 1);
    check_eq("short_acc_cnt", n_acc - base_acc, 1);
    check_eq("short_left", acc_l, fl[0]);
    check_eq("short_right", acc_r, fr[0]);

    // Random slot lengths and random back-pressure
    rand_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send_slot(1'b0, 16'($urandom), $urandom_range(W + 1, 32));
      send_slot(1'b1, 16'($urandom), $urandom_range(W + 1, 32));
    end
    rand_ready = 1'b0;

    // Asynchronous reset in the middle of a left-slot capture
    sample_ready = 1'b0;
    send_frame(16'($urandom), 16'($urandom));
    check_eq("pre_rst_valid", sample_valid, 1'b1);
    send_slot(1'b0, 16'($urandom), 12);
    do_reset();
    base_acc = n_acc;
    sample_ready = 1'b1;
    send_slot(1'b0, 16'($urandom), 20);
    send_slot(1'b1, 16'($urandom), 32);
    check_eq("post_rst_valid", sample_valid, 1'b0);
    check_eq("post_rst_lock", locked, 1'b0);
    fl[0] = 16'($urandom); fr[0] = 16'($urandom);
    send_frame(fl[0], fr[0]);
    check_eq("post_rst_acc", n_acc - base_acc, 1);
    check_eq("post_rst_left", acc_l, fl[0]);
    check_eq("post_rst_right", acc_r, fr[0]);
    check_eq("post_rst_lock_on", locked, 1'b1);

    repeat (20) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
